// File: rtl/onn_recall_sequencer.sv
// rtl/onn_recall_sequencer.sv - load, run and capture one ONN pattern-recall pass
module onn_recall_sequencer #(
    parameter int STATE_W       = 60,
    parameter int MAX_CYCLES    = 4096,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int STEADY_HOLD   = 4
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [STATE_W-1:0] pattern,
    output logic               onn_data_in,
    output logic               onn_load,
    output logic               onn_re,
    input  logic               onn_steady,
    input  logic               onn_inconsistent,
    input  logic [STATE_W-1:0] onn_phi,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [STATE_W-1:0] result_phi,
    output logic [CNT_W-1:0]   cycles_used
);

    localparam int BIT_W = $clog2(STATE_W);
    localparam logic [BIT_W-1:0] L_LAST_BIT    = BIT_W'(STATE_W - 1);
    localparam logic [CNT_W-1:0] L_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_MAX         = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] L_HOLD        = CNT_W'(STEADY_HOLD);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] ST_CONV    = 2'b01;
    localparam logic [1:0] ST_INCONS  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    logic [2:0]         r_state;
    logic [STATE_W-1:0] r_shift;
    logic [BIT_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_settle;
    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_hold;
    logic               r_data;
    logic               r_load;
    logic               r_re;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_status;
    logic [STATE_W-1:0] r_phi;
    logic [CNT_W-1:0]   r_cycles;

    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] w_cyc_next;
    logic [CNT_W-1:0] w_hold_next;
    logic             w_conv;
    logic             w_tmo;
    logic             w_exit;
    logic [1:0]       w_exit_status;

    // Exit checks look at the counts including the current cycle, so the
    // capture lands on the same edge that the condition first holds.
    always_comb begin
        w_cyc_next    = r_cyc + 1'b1;
        w_hold_next   = onn_steady ? (r_hold + 1'b1) : '0;
        w_conv        = (w_hold_next == L_HOLD);
        w_tmo         = (w_cyc_next == L_MAX);
        w_exit_status = onn_inconsistent ? ST_INCONS : (w_conv ? ST_CONV : ST_TIMEOUT);
        w_state_next  = r_state;
        case (r_state)
            S_IDLE:   if (start && !abort) w_state_next = S_LOAD;
            S_LOAD: begin
                if (abort)                    w_state_next = S_IDLE;
                else if (r_bit == L_LAST_BIT) w_state_next = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                          w_state_next = S_IDLE;
                else if (r_settle == L_SETTLE_LAST) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (abort)                                    w_state_next = S_IDLE;
                else if (onn_inconsistent || w_conv || w_tmo) w_state_next = S_DONE;
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        w_exit = (r_state == S_RUN) && (w_state_next == S_DONE);
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_settle <= '0;
            r_cyc    <= '0;
            r_hold   <= '0;
            r_data   <= 1'b0;
            r_load   <= 1'b0;
            r_re     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_status <= 2'b00;
            r_phi    <= '0;
            r_cycles <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_load  <= (w_state_next == S_LOAD);
            r_re    <= (w_state_next == S_RUN);
            r_done  <= w_exit;
            r_data  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_state_next == S_LOAD) begin
                        r_data   <= pattern[0];
                        r_shift  <= pattern >> 1;
                        r_bit    <= '0;
                        r_settle <= '0;
                        r_cyc    <= '0;
                        r_hold   <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_state_next == S_LOAD) begin
                        r_data  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                S_SETTLE: r_settle <= r_settle + 1'b1;
                S_RUN: begin
                    r_cyc  <= w_cyc_next;
                    r_hold <= w_hold_next;
                end
                default: ;
            endcase
            if (w_exit) begin
                r_status <= w_exit_status;
                r_phi    <= onn_phi;
                r_cycles <= w_cyc_next;
            end
        end
    end

    assign onn_data_in = r_data;
    assign onn_load    = r_load;
    assign onn_re      = r_re;
    assign busy        = r_busy;
    assign done        = r_done;
    assign status      = r_status;
    assign result_phi  = r_phi;
    assign cycles_used = r_cycles;

endmodule

// File: tb/tb_onn_recall_sequencer.sv
// tb/tb_onn_recall_sequencer.sv - randomized recall runs against a trace-scanning reference model
module tb_onn_recall_sequencer;

    localparam int TR_N = 200;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        steady = 1'b0;
    logic        incons = 1'b0;
    logic [59:0] pattern = '0;
    logic [59:0] phi = '0;

    logic        data0, load0, re0, busy0, done0;
    logic [1:0]  st0;
    logic [59:0] rphi0;
    logic [15:0] cu0;
    logic        data1, load1, re1, busy1, done1;
    logic [1:0]  st1;
    logic [59:0] rphi1;
    logic [15:0] cu1;

    int n_vec;
    int n_err;
    int m_st0, m_cu0, m_st1, m_cu1;
    logic [59:0] m_phi0, m_phi1;

    bit          tr_s [1:TR_N];
    bit          tr_i [1:TR_N];
    logic [59:0] rec_phi [1:TR_N];

    always #5 sclk = ~sclk;

    onn_recall_sequencer u_dut (
        .sclk(sclk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
        .onn_data_in(data0), .onn_load(load0), .onn_re(re0),
        .onn_steady(steady), .onn_inconsistent(incons), .onn_phi(phi),
        .busy(busy0), .done(done0), .status(st0), .result_phi(rphi0), .cycles_used(cu0)
    );

    onn_recall_sequencer #(.MAX_CYCLES(8)) u_dut8 (
        .sclk(sclk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
        .onn_data_in(data1), .onn_load(load1), .onn_re(re1),
        .onn_steady(steady), .onn_inconsistent(incons), .onn_phi(phi),
        .busy(busy1), .done(done1), .status(st1), .result_phi(rphi1), .cycles_used(cu1)
    );

    // Outcome of a run read straight off the flag trace: first inconsistent
    // cycle, first cycle ending four consecutive steady cycles, or the budget.
    function automatic void model(input int maxc, output int st, output int cyc);
        st = 0;
        cyc = 0;
        for (int i = 1; i <= TR_N; i++) begin
            if (tr_i[i]) begin st = 2; cyc = i; return; end
            if (i >= 4 && tr_s[i] && tr_s[i-1] && tr_s[i-2] && tr_s[i-3]) begin st = 1; cyc = i; return; end
            if (i == maxc) begin st = 3; cyc = i; return; end
        end
    endfunction

    task automatic clear_trace();
        for (int i = 1; i <= TR_N; i++) begin
            tr_s[i] = 1'b0;
            tr_i[i] = 1'b0;
        end
    endtask

    task automatic run_one(input logic [59:0] pat, input int abort_at, input bit start_noise);
        int e_st0, e_cu0, e_st1, e_cu1, stop;
        bit ab0, ab1;
        model(4096, e_st0, e_cu0);
        model(8, e_st1, e_cu1);
        ab0  = (abort_at > 0) && (abort_at <= e_cu0);
        ab1  = (abort_at > 0) && (abort_at <= e_cu1);
        stop = ab0 ? abort_at : e_cu0;
        @(negedge sclk);
        pattern = pat;
        start = 1'b1;
        for (int k = 1; k <= 62; k++) begin
            logic exp_load, exp_data;
            @(negedge sclk);
            start   = start_noise ? 1'($urandom_range(1)) : 1'b0;
            pattern = 60'({$urandom(), $urandom()});
            exp_load = (k <= 60);
            exp_data = (k <= 60) ? pat[k-1] : 1'b0;
            n_vec++;
            if (load0 !== exp_load || data0 !== exp_data || re0 !== 1'b0 || busy0 !== 1'b1 || load1 !== exp_load) begin
                n_err++;
                $display("FAIL load k=%0d got load=%b data=%b re=%b busy=%b load8=%b want load=%b data=%b re=0 busy=1",
                         k, load0, data0, re0, busy0, load1, exp_load, exp_data);
            end
        end
        start = 1'b0;
        for (int j = 1; j <= stop + 1; j++) begin
            @(negedge sclk);
            if (j <= stop) begin
                n_vec++;
                if (re0 !== 1'b1 || load0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL run j=%0d got re=%b load=%b done=%b busy=%b want 1/0/0/1", j, re0, load0, done0, busy0);
                end
            end else if (ab0) begin
                n_vec++;
                if (done0 !== 1'b0 || re0 !== 1'b0 || busy0 !== 1'b0 || st0 !== 2'(m_st0) || cu0 !== 16'(m_cu0) || rphi0 !== m_phi0) begin
                    n_err++;
                    $display("FAIL abort got done=%b re=%b busy=%b st=%0d cu=%0d want 0/0/0 st=%0d cu=%0d",
                             done0, re0, busy0, st0, cu0, m_st0, m_cu0);
                end
            end else begin
                n_vec++;
                if (done0 !== 1'b1 || re0 !== 1'b0 || st0 !== 2'(e_st0) || cu0 !== 16'(e_cu0) || rphi0 !== rec_phi[e_cu0]) begin
                    n_err++;
                    $display("FAIL exit got done=%b re=%b st=%0d cu=%0d phi=%h want done=1 re=0 st=%0d cu=%0d phi=%h",
                             done0, re0, st0, cu0, rphi0, e_st0, e_cu0, rec_phi[e_cu0]);
                end
                m_st0 = e_st0; m_cu0 = e_cu0; m_phi0 = rec_phi[e_cu0];
            end
            if (!ab1 && j == e_cu1 + 1) begin
                n_vec++;
                if (done1 !== 1'b1 || st1 !== 2'(e_st1) || cu1 !== 16'(e_cu1) || rphi1 !== rec_phi[e_cu1]) begin
                    n_err++;
                    $display("FAIL exit8 got done=%b st=%0d cu=%0d want done=1 st=%0d cu=%0d", done1, st1, cu1, e_st1, e_cu1);
                end
                m_st1 = e_st1; m_cu1 = e_cu1; m_phi1 = rec_phi[e_cu1];
            end
            if (j <= stop) begin
                abort  = (j == abort_at);
                steady = tr_s[j];
                incons = tr_i[j];
                phi    = 60'({$urandom(), $urandom()});
                rec_phi[j] = phi;
            end else begin
                abort = 1'b0; steady = 1'b0; incons = 1'b0;
                start = (!ab0 && !ab1 && e_cu1 == e_cu0);
            end
        end
        if (!ab0) begin
            @(negedge sclk);
            start = 1'b0;
            n_vec++;
            if (done0 !== 1'b0 || busy0 !== 1'b0 || re0 !== 1'b0) begin
                n_err++;
                $display("FAIL post_done got done=%b busy=%b re=%b want 0/0/0", done0, busy0, re0);
            end
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({data0, load0, re0, busy0, done0} !== 5'b0 || st0 !== 2'b0 || rphi0 !== 60'b0 || cu0 !== 16'b0 ||
            {data1, load1, re1, busy1, done1} !== 5'b0 || st1 !== 2'b0 || rphi1 !== 60'b0 || cu1 !== 16'b0) begin
            n_err++;
            $display("FAIL %s got ctl=%b%b%b%b%b st=%0d cu=%0d phi=%h want all zero", name, data0, load0, re0, busy0, done0, st0, cu0, rphi0);
        end
        m_st0 = 0; m_cu0 = 0; m_phi0 = '0; m_st1 = 0; m_cu1 = 0; m_phi1 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_load_order();
        clear_trace();
        for (int j = 10; j <= TR_N; j++) tr_s[j] = 1'b1;
        run_one(60'h0123456789ABCDE, 0, 1'b0);
    endtask

    task automatic test_glitchy();
        clear_trace();
        for (int j = 5; j <= 7; j++) tr_s[j] = 1'b1;
        for (int j = 9; j <= TR_N; j++) tr_s[j] = 1'b1;
        run_one(60'({$urandom(), $urandom()}), 0, 1'b1);
    endtask

    task automatic test_priority();
        clear_trace();
        for (int j = 3; j <= TR_N; j++) tr_s[j] = 1'b1;
        tr_i[6] = 1'b1;
        run_one(60'({$urandom(), $urandom()}), 0, 1'b1);
    endtask

    task automatic test_abort();
        clear_trace();
        for (int j = 20; j <= TR_N; j++) tr_s[j] = 1'b1;
        run_one(60'({$urandom(), $urandom()}), 5, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            clear_trace();
            for (int j = 1; j <= TR_N; j++) begin
                tr_s[j] = ($urandom_range(3) != 0);
                tr_i[j] = ($urandom_range(40) == 0);
            end
            for (int j = 150; j <= TR_N; j++) tr_s[j] = 1'b1;
            run_one(60'({$urandom(), $urandom()}), 0, 1'(n % 2));
        end
    endtask

    task automatic test_reset_mid_load();
        logic [59:0] pat;
        pat = 60'({$urandom(), $urandom()});
        @(negedge sclk);
        pattern = pat;
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        repeat (30) @(negedge sclk);
        n_vec++;
        if (load0 !== 1'b1 || data0 !== pat[30]) begin
            n_err++;
            $display("FAIL mid_load got load=%b data=%b want load=1 data=%b", load0, data0, pat[30]);
        end
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid_load");
        @(negedge sclk);
        rst_n = 1'b1;
        clear_trace();
        for (int j = 7; j <= TR_N; j++) tr_s[j] = 1'b1;
        run_one(60'({$urandom(), $urandom()}), 0, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_st0 = 0; m_cu0 = 0; m_phi0 = '0;
        m_st1 = 0; m_cu1 = 0; m_phi1 = '0;
        test_reset();
        test_load_order();
        test_glitchy();
        test_priority();
        test_abort();
        test_random();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
